// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the default 32x32 register file.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int NREGS_DEF = 1 << REG_W;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;
endpackage

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: port arrays and scoreboard signals of the multi-port register file.
interface register_file_mp_if #(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
);
    logic [NWR-1:0]         wen;
    logic [NWR-1:0][AW-1:0] wsel;
    logic [NWR-1:0][DW-1:0] wdat;
    logic [NRD-1:0][AW-1:0] rsel;
    logic [NRD-1:0][DW-1:0] rdat;
    logic [NRD-1:0]         rbusy;
    logic                   iss_en;
    logic [AW-1:0]          iss_sel;
    logic                   iss_ok;
    logic                   flush;
    modport rf  (input wen, wsel, wdat, rsel, iss_en, iss_sel, flush, output rdat, rbusy, iss_ok);
    modport dec (output rsel, iss_en, iss_sel, flush, input rdat, rbusy, iss_ok);
    modport wb  (output wen, wsel, wdat);
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write flags with issue/writeback/flush/reset priority.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NWR-1:0]         wen,
    input  logic [NWR-1:0][AW-1:0] wsel,
    input  logic [NRD-1:0][AW-1:0] rsel,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_sel,
    input  logic                   flush,
    output logic                   iss_ok,
    output logic [NRD-1:0]         rbusy
);
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] wmask;
    logic [NREGS-1:0] set_mask;

    always_comb begin
        wmask = '0;
        for (int p = 0; p < NWR; p++)
            if (wen[p]) wmask[wsel[p]] = 1'b1;
        wmask[0] = 1'b0;
    end

    assign iss_ok = RST || iss_sel == '0 || !pend[iss_sel] || wmask[iss_sel];

    always_comb begin
        set_mask = '0;
        set_mask[iss_sel] = iss_en && iss_ok && iss_sel != '0;
    end

    always_comb begin
        rbusy = '0;
        for (int r = 0; r < NRD; r++)
            rbusy[r] = !RST && pend[rsel[r]] && !wmask[rsel[r]];
    end

    // Set is OR'd after the clear so a new producer keeps the flag on a same-cycle writeback.
    always_ff @(posedge CLK) begin
        if (RST || flush)
            pend <= '0;
        else
            pend <= (pend & ~wmask) | set_mask;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-to-read bypass and pending-write scoreboard.
module regfile_mp
    import cpu_types_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int DW    = WORD_W,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NWR-1:0]         wen,
    input  logic [NWR-1:0][AW-1:0] wsel,
    input  logic [NWR-1:0][DW-1:0] wdat,
    input  logic [NRD-1:0][AW-1:0] rsel,
    output logic [NRD-1:0][DW-1:0] rdat,
    output logic [NRD-1:0]         rbusy,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_sel,
    output logic                   iss_ok,
    input  logic                   flush
);
    logic [DW-1:0] regs [NREGS];

    // Ascending port loop: the last matching port (highest index) wins, for storage and bypass alike.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (wen[p] && wsel[p] != '0) regs[wsel[p]] <= wdat[p];
        end
    end

    always_comb begin
        rdat = '0;
        for (int r = 0; r < NRD; r++) begin
            rdat[r] = regs[rsel[r]];
            for (int p = 0; p < NWR; p++)
                if (wen[p] && wsel[p] == rsel[r]) rdat[r] = wdat[p];
            if (RST || rsel[r] == '0) rdat[r] = '0;
        end
    end

    rf_scoreboard #(.NREGS(NREGS), .NRD(NRD), .NWR(NWR), .AW(AW)) u_sb (
        .CLK(CLK),
        .RST(RST),
        .wen(wen),
        .wsel(wsel),
        .rsel(rsel),
        .iss_en(iss_en),
        .iss_sel(iss_sel),
        .flush(flush),
        .iss_ok(iss_ok),
        .rbusy(rbusy)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of bypass, write priority, scoreboard, flush and reset.
module tb_regfile_mp;
    logic             CLK = 1'b0;
    logic             RST;
    logic [1:0]       wen;
    logic [1:0][4:0]  wsel;
    logic [1:0][31:0] wdat;
    logic [1:0][4:0]  rsel;
    logic [1:0][31:0] rdat;
    logic [1:0]       rbusy;
    logic             iss_en;
    logic [4:0]       iss_sel;
    logic             iss_ok;
    logic             flush;
    int checks = 0;
    int errors = 0;

    regfile_mp #(.NREGS(32), .DW(32), .NRD(2), .NWR(2)) dut (
        .CLK(CLK), .RST(RST), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
        .iss_en(iss_en), .iss_sel(iss_sel), .iss_ok(iss_ok), .flush(flush)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RST = 1'b0; wen = '0; wsel = '0; wdat = '0; rsel = '0;
        iss_en = 1'b0; iss_sel = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rsel[0] = 5'(i); rsel[1] = 5'(31 - i); iss_sel = 5'(i);
            #1;
            checks++;
            if (rdat !== '0 || rbusy !== 2'b00 || iss_ok !== 1'b1) begin
                errors++;
                $display("FAIL reset_r%0d: rdat=%h rbusy=%b iss_ok=%b expected 0/00/1", i, rdat, rbusy, iss_ok);
            end
        end
    endtask

    task automatic test_write_bypass();
        idle();
        wen[0] = 1'b1; wsel[0] = 5'd5; wdat[0] = 32'hDEADBEEF; rsel[0] = 5'd5;
        #1;
        checks++;
        if (rdat[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_r5: got %h expected deadbeef", rdat[0]); end
        tick();
        wen = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (rdat[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_r5: got %h expected deadbeef", rdat[0]); end
            tick();
        end
        wen[0] = 1'b1; wsel[0] = 5'd0; wdat[0] = 32'h1234; rsel[0] = 5'd0; rsel[1] = 5'd5;
        #1;
        checks++;
        if (rdat[0] !== 32'h0 || rdat[1] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL r0_write_same: got %h/%h expected 0/deadbeef", rdat[0], rdat[1]);
        end
        tick();
        wen = '0;
        #1;
        checks++;
        if (rdat[0] !== 32'h0) begin errors++; $display("FAIL r0_write_after: got %h expected 0", rdat[0]); end
    endtask

    task automatic test_collision();
        idle();
        wen = 2'b11; wsel[0] = 5'd7; wsel[1] = 5'd7; wdat[0] = 32'h11; wdat[1] = 32'h22;
        rsel[0] = 5'd7; rsel[1] = 5'd7;
        #1;
        checks++;
        if (rdat[1] !== 32'h22 || rdat[0] !== 32'h22) begin
            errors++; $display("FAIL collision_bypass: got %h/%h expected 22/22", rdat[0], rdat[1]);
        end
        tick();
        wen = '0;
        #1;
        checks++;
        if (rdat[1] !== 32'h22) begin errors++; $display("FAIL collision_stored: got %h expected 22", rdat[1]); end
        wen = 2'b01; wsel[0] = 5'd7; wdat[0] = 32'h33; wsel[1] = 5'd8; wdat[1] = 32'h44;
        #1;
        checks++;
        if (rdat[0] !== 32'h33) begin errors++; $display("FAIL port0_only_bypass: got %h expected 33", rdat[0]); end
        tick();
        wen = '0;
        rsel[1] = 5'd8;
        #1;
        checks++;
        if (rdat[0] !== 32'h33 || rdat[1] !== 32'h0) begin
            errors++; $display("FAIL port0_only_stored: got %h/%h expected 33/0", rdat[0], rdat[1]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_en = 1'b1; iss_sel = 5'd9;
        #1;
        checks++;
        if (iss_ok !== 1'b1) begin errors++; $display("FAIL issue_r9_ok: got %b expected 1", iss_ok); end
        tick();
        iss_en = 1'b0; rsel[0] = 5'd9;
        #1;
        checks++;
        if (iss_ok !== 1'b0 || rbusy[0] !== 1'b1) begin
            errors++; $display("FAIL r9_pending: iss_ok=%b rbusy=%b expected 0/1", iss_ok, rbusy[0]);
        end
        wen[0] = 1'b1; wsel[0] = 5'd9; wdat[0] = 32'h55;
        #1;
        checks++;
        if (rbusy[0] !== 1'b0 || rdat[0] !== 32'h55 || iss_ok !== 1'b1) begin
            errors++; $display("FAIL r9_writeback: rbusy=%b rdat=%h iss_ok=%b expected 0/55/1", rbusy[0], rdat[0], iss_ok);
        end
        tick();
        wen = '0;
        #1;
        checks++;
        if (rbusy[0] !== 1'b0 || iss_ok !== 1'b1 || rdat[0] !== 32'h55) begin
            errors++; $display("FAIL r9_cleared: rbusy=%b iss_ok=%b rdat=%h expected 0/1/55", rbusy[0], iss_ok, rdat[0]);
        end
    endtask

    task automatic test_set_wins_flush();
        idle();
        iss_en = 1'b1; iss_sel = 5'd3; wen[0] = 1'b1; wsel[0] = 5'd3; wdat[0] = 32'hA;
        tick();
        idle();
        rsel[0] = 5'd3; iss_sel = 5'd3;
        #1;
        checks++;
        if (rbusy[0] !== 1'b1 || iss_ok !== 1'b0) begin
            errors++; $display("FAIL set_wins: rbusy=%b iss_ok=%b expected 1/0", rbusy[0], iss_ok);
        end
        flush = 1'b1; iss_en = 1'b1; iss_sel = 5'd4;
        tick();
        idle();
        rsel[0] = 5'd3; rsel[1] = 5'd4; iss_sel = 5'd4;
        #1;
        checks++;
        if (rbusy !== 2'b00 || iss_ok !== 1'b1) begin
            errors++; $display("FAIL flush: rbusy=%b iss_ok=%b expected 00/1", rbusy, iss_ok);
        end
        iss_sel = 5'd3;
        #1;
        checks++;
        if (iss_ok !== 1'b1) begin errors++; $display("FAIL flush_r3_ok: got %b expected 1", iss_ok); end
    endtask

    task automatic test_reset_mid();
        idle();
        iss_en = 1'b1; iss_sel = 5'd2;
        wen[1] = 1'b1; wsel[1] = 5'd6; wdat[1] = 32'hCAFE;
        tick();
        idle();
        rsel[0] = 5'd2; rsel[1] = 5'd6;
        #1;
        checks++;
        if (rbusy[0] !== 1'b1 || rdat[1] !== 32'hCAFE) begin
            errors++; $display("FAIL pre_reset: rbusy=%b rdat=%h expected 1/cafe", rbusy[0], rdat[1]);
        end
        RST = 1'b1; wen[0] = 1'b1; wsel[0] = 5'd2; wdat[0] = 32'h77; iss_en = 1'b1; iss_sel = 5'd6;
        #1;
        checks++;
        if (rdat !== '0 || rbusy !== 2'b00 || iss_ok !== 1'b1) begin
            errors++; $display("FAIL during_reset: rdat=%h rbusy=%b iss_ok=%b expected 0/00/1", rdat, rbusy, iss_ok);
        end
        tick();
        idle();
        rsel[0] = 5'd2; rsel[1] = 5'd6; iss_sel = 5'd6;
        #1;
        checks++;
        if (rdat !== '0 || rbusy !== 2'b00 || iss_ok !== 1'b1) begin
            errors++; $display("FAIL after_reset: rdat=%h rbusy=%b iss_ok=%b expected 0/00/1", rdat, rbusy, iss_ok);
        end
        rsel[0] = 5'd9; rsel[1] = 5'd7; iss_sel = 5'd2;
        #1;
        checks++;
        if (rdat !== '0 || iss_ok !== 1'b1) begin
            errors++; $display("FAIL after_reset_others: rdat=%h iss_ok=%b expected 0/1", rdat, iss_ok);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_bypass();
        test_collision();
        test_scoreboard();
        test_set_wins_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
